// File: rtl/reg_view_seg_if.sv
// Debug-port / display bundle for reg_view_seg.
//   mode, sw_sel, step_btn : board controls (asynchronous to clk)
//   reg_sel, reg_data      : register-read port of the computer
//   seg_an, seg_cat        : active-low multiplexed 7-segment display
// master = the viewer, slave = the board/computer side.
interface reg_view_seg_if;
    logic        mode;
    logic [4:0]  sw_sel;
    logic        step_btn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    modport master (
        input  mode, sw_sel, step_btn, reg_data,
        output reg_sel, seg_an, seg_cat
    );

    modport slave (
        output mode, sw_sel, step_btn, reg_data,
        input  reg_sel, seg_an, seg_cat
    );
endinterface

// File: rtl/reg_view_seg.sv
// reg_view_seg: register viewer for the single-cycle computer's read port.
// Selects a register (manual from switches, or auto sweep with button
// stepping) and shows its 32-bit value as 8 hex digits on a multiplexed
// active-low 7-segment display.
// Ports:
//   clk  - system clock, rising edge
//   rstn - asynchronous active-low reset
//   bus  - reg_view_seg_if.master (controls, reg_sel/reg_data, seg_an/seg_cat)
// Parameters:
//   CLK_DIV_W  - digit advances every 2^CLK_DIV_W cycles
//   STEP_DIV_W - auto sweep advances every 2^STEP_DIV_W cycles
// Optional macro REG_VIEW_DP_EN: show reg_sel in binary on the decimal
// points of digits 0..4; when undefined dp stays off.
module reg_view_seg #(
    parameter int unsigned CLK_DIV_W  = 16,
    parameter int unsigned STEP_DIV_W = 26
) (
    input  logic           clk,
    input  logic           rstn,
    reg_view_seg_if.master bus
);

    // Two-flop synchronisers plus a delay flop for the button edge
    logic       mode_s1, mode_s2;
    logic [4:0] sw_s1, sw_s2;
    logic       btn_s1, btn_s2, btn_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_d   <= 1'b0;
        end else begin
            mode_s1 <= bus.mode;
            mode_s2 <= mode_s1;
            sw_s1   <= bus.sw_sel;
            sw_s2   <= sw_s1;
            btn_s1  <= bus.step_btn;
            btn_s2  <= btn_s1;
            btn_d   <= btn_s2;
        end
    end

    logic step_pulse;
    assign step_pulse = btn_s2 & ~btn_d;

    // Register selection: manual follow or auto sweep
    logic [4:0]            sel_q;
    logic [STEP_DIV_W-1:0] step_div;
    logic                  step_wrap;

    assign step_wrap = &step_div;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q    <= '0;
            step_div <= '0;
        end else if (!mode_s2) begin
            sel_q    <= sw_s2;
            step_div <= '0;
        end else if (step_pulse) begin
            // A coincident wrap is absorbed here: one step only
            sel_q    <= sel_q + 5'd1;
            step_div <= '0;
        end else begin
            step_div <= step_div + STEP_DIV_W'(1);
            if (step_wrap) begin
                sel_q <= sel_q + 5'd1;
            end
        end
    end

    assign bus.reg_sel = sel_q;

    // Digit scan and per-frame snapshot of the register value
    logic [CLK_DIV_W-1:0] ref_div;
    logic [2:0]           digit;
    logic [31:0]          disp_data;
    logic                 digit_tick;

    assign digit_tick = &ref_div;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_div   <= '0;
            digit     <= '0;
            disp_data <= '0;
        end else begin
            ref_div <= ref_div + CLK_DIV_W'(1);
            if (digit_tick) begin
                digit <= digit + 3'd1;
                // Latch at frame start so every digit of a frame shows one value
                if (digit == 3'd7) begin
                    disp_data <= bus.reg_data;
                end
            end
        end
    end

    // Hex decode of the current nibble, {g,f,e,d,c,b,a} active-low
    logic [3:0] nibble;
    logic [6:0] seg7;
    logic       dp;

    assign nibble = disp_data[{digit, 2'b00} +: 4];

    always_comb begin
        seg7 = 7'h7F;
        case (nibble)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            4'hF: seg7 = 7'h0E;
            default: seg7 = 7'h7F;
        endcase
    end

`ifdef REG_VIEW_DP_EN
    // Digits 5..7 map to zero bits so their dp stays dark
    logic [7:0] dp_map;
    assign dp_map = {3'b000, sel_q};
    assign dp     = ~dp_map[digit];
`else
    assign dp = 1'b1;
`endif

    // Registered display drive
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.seg_an  <= 8'hFF;
            bus.seg_cat <= 8'hFF;
        end else begin
            bus.seg_an  <= ~(8'h01 << digit);
            bus.seg_cat <= {dp, seg7};
        end
    end

endmodule

// File: tb/tb_reg_view_seg.sv
// Bench for reg_view_seg: random and directed stimulus, a cycle-indexed
// reference model that predicts every digit presentation and reg_sel change,
// and a negedge monitor that pops and compares those predictions.
module tb_reg_view_seg;

    localparam int unsigned CDW   = 2;
    localparam int unsigned SDW   = 4;
    localparam int          DIV   = 1 << CDW;
    localparam int          STEP  = 1 << SDW;
    localparam int          FRAME = 8 * DIV;
    localparam logic [7:0]  HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] regs [32];

    reg_view_seg_if bus ();
    assign bus.reg_data = regs[bus.reg_sel];

    reg_view_seg #(.CLK_DIV_W(CDW), .STEP_DIV_W(SDW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [7:0] cat;
    } disp_t;

    typedef struct {
        int         cyc;
        logic [4:0] sel;
    } sel_t;

    disp_t dq [$];
    sel_t  sq [$];

    int checks = 0;
    int errors = 0;

    // Reference model state (cycle count since reset release)
    int          cyc    = 0;
    int          m_sel  = 0;
    int          m_sdiv = 0;
    logic [31:0] m_disp = '0;
    logic        mode_h [3];
    int          sw_h   [3];
    logic        btn_h  [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sdiv(input int v);
        for (int i = 0; i < 2 * STEP; i++) begin
            if (m_sdiv == v) break;
            tick(1);
        end
    endtask

    // Reference model: digit i of frame is shown for DIV cycles, frame value
    // snapped at each frame boundary; inputs reach the logic two edges late.
    initial begin
        int         d;
        int         old;
        logic [3:0] nib;
        logic       dp;
        logic       pulse;
        disp_t      de;
        sel_t       se;
        for (int i = 0; i < 3; i++) begin
            mode_h[i] = 1'b0;
            sw_h[i]   = 0;
            btn_h[i]  = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                while (dq.size() > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL disp_lost: cycle %0d digit never shown", dq[0].cyc);
                    void'(dq.pop_front());
                end
                while (sq.size() > 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sel_lost: cycle %0d reg_sel %0d never shown", sq[0].cyc, sq[0].sel);
                    void'(sq.pop_front());
                end
                cyc    = 0;
                m_sel  = 0;
                m_sdiv = 0;
                m_disp = '0;
                for (int i = 0; i < 3; i++) begin
                    mode_h[i] = 1'b0;
                    sw_h[i]   = 0;
                    btn_h[i]  = 1'b0;
                end
            end else begin
                cyc++;
                if ((cyc - 1) % DIV == 0) begin
                    d   = ((cyc - 1) / DIV) % 8;
                    nib = m_disp[4*d +: 4];
                    dp  = 1'b1;
`ifdef REG_VIEW_DP_EN
                    if (d < 5 && ((m_sel >> d) & 1) == 1) dp = 1'b0;
`endif
                    de.cyc = cyc;
                    de.an  = 8'hFF ^ (8'h01 << d);
                    de.cat = {dp, HEX[nib][6:0]};
                    dq.push_back(de);
                end
                if (cyc % FRAME == 0) m_disp = regs[m_sel];

                old   = m_sel;
                pulse = btn_h[1] && !btn_h[2];
                if (!mode_h[1]) begin
                    m_sel  = sw_h[1];
                    m_sdiv = 0;
                end else if (pulse) begin
                    m_sel  = (m_sel + 1) % 32;
                    m_sdiv = 0;
                end else begin
                    m_sdiv = m_sdiv + 1;
                    if (m_sdiv == STEP) begin
                        m_sdiv = 0;
                        m_sel  = (m_sel + 1) % 32;
                    end
                end
                if (m_sel != old) begin
                    se.cyc = cyc;
                    se.sel = 5'(m_sel);
                    sq.push_back(se);
                end

                mode_h[2] = mode_h[1]; mode_h[1] = mode_h[0]; mode_h[0] = bus.mode;
                sw_h[2]   = sw_h[1];   sw_h[1]   = sw_h[0];   sw_h[0]   = int'(bus.sw_sel);
                btn_h[2]  = btn_h[1];  btn_h[1]  = btn_h[0];  btn_h[0]  = bus.step_btn;
            end
        end
    end

    // Monitor: every seg_an / reg_sel change must match the next prediction
    initial begin
        logic [7:0] prev_an;
        logic [4:0] prev_sel;
        disp_t      e;
        sel_t       s;
        prev_an  = 8'hFF;
        prev_sel = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                while (dq.size() > 0 && dq[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL disp_missed: cycle %0d want an %h cat %h, display did not change", dq[0].cyc, dq[0].an, dq[0].cat);
                    void'(dq.pop_front());
                end
                while (sq.size() > 0 && sq[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sel_missed: cycle %0d want reg_sel %0d, got %0d", sq[0].cyc, sq[0].sel, bus.reg_sel);
                    void'(sq.pop_front());
                end
                if (bus.seg_an !== prev_an) begin
                    checks++;
                    if (dq.size() == 0) begin
                        errors++;
                        $display("FAIL disp_unexpected: cycle %0d got an %h cat %h, no change expected", cyc, bus.seg_an, bus.seg_cat);
                    end else begin
                        e = dq.pop_front();
                        if (e.cyc != cyc || e.an !== bus.seg_an || e.cat !== bus.seg_cat) begin
                            errors++;
                            $display("FAIL disp: cycle %0d got an %h cat %h, want cycle %0d an %h cat %h",
                                     cyc, bus.seg_an, bus.seg_cat, e.cyc, e.an, e.cat);
                        end
                    end
                end
                if (bus.reg_sel !== prev_sel) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL sel_unexpected: cycle %0d got reg_sel %0d, want %0d", cyc, bus.reg_sel, prev_sel);
                    end else begin
                        s = sq.pop_front();
                        if (s.cyc != cyc || s.sel !== bus.reg_sel) begin
                            errors++;
                            $display("FAIL sel: cycle %0d got reg_sel %0d, want cycle %0d reg_sel %0d",
                                     cyc, bus.reg_sel, s.cyc, s.sel);
                        end
                    end
                end
            end
            prev_an  = bus.seg_an;
            prev_sel = bus.reg_sel;
        end
    end

    // Stimulus
    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[7]      = 32'h1234ABCD;
        bus.mode     = 1'b0;
        bus.sw_sel   = 5'd7;
        bus.step_btn = 1'b0;
        rstn         = 1'b0;
        tick(3);
        #2 rstn = 1'b1;

        // First post-reset presentation and manual follow latency
        @(posedge clk); #1;
        check("first_an", 32'(bus.seg_an), 32'h0000_00FE);
        check("first_cat", 32'(bus.seg_cat), 32'h0000_00C0);
        @(posedge clk); @(posedge clk); #1;
        check("manual_sel", 32'(bus.reg_sel), 32'd7);

        // Manual decode of 1234ABCD over several frames
        tick(3 * FRAME);

        // Auto sweep from 30 through the 31 -> 0 wrap
        bus.sw_sel = 5'd30;
        tick(6);
        bus.mode = 1'b1;
        tick(3 * STEP + 4);

        // Long press landing at divider 9
        wait_sdiv(7);
        bus.step_btn = 1'b1;
        tick(40);
        bus.step_btn = 1'b0;
        tick(STEP + 4);

        // Press landing on the divider wrap
        wait_sdiv(13);
        bus.step_btn = 1'b1;
        tick(10);
        bus.step_btn = 1'b0;
        tick(STEP + 4);

        // Snapshot coherence: new data while digit 3 is on screen
        bus.mode   = 1'b0;
        bus.sw_sel = 5'd12;
        tick(FRAME + 4);
        for (int i = 0; i < FRAME; i++) begin
            if ((cyc / DIV) % 8 == 3) break;
            tick(1);
        end
        regs[12] = $urandom;
        tick(2 * FRAME);

        // dp pattern 10101 held for a couple of frames
        bus.sw_sel = 5'b10101;
        tick(2 * FRAME);

        // Randomised mix of mode, switches, button and data changes
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: bus.mode = ~bus.mode;
                1: bus.sw_sel = 5'($urandom);
                2: bus.step_btn = ~bus.step_btn;
                3: regs[$urandom_range(0, 31)] = $urandom;
                4: regs[m_sel] = $urandom;
                default: ;
            endcase
            tick($urandom_range(1, 12));
        end

        // Reset in the middle of a frame
        bus.mode = 1'b1;
        tick(FRAME / 2 + 3);
        #2 rstn = 1'b0;
        #1;
        check("rst_an", 32'(bus.seg_an), 32'h0000_00FF);
        check("rst_cat", 32'(bus.seg_cat), 32'h0000_00FF);
        check("rst_sel", 32'(bus.reg_sel), 32'd0);
        tick(2);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        check("rerst_an", 32'(bus.seg_an), 32'h0000_00FE);
        check("rerst_cat", 32'(bus.seg_cat), 32'h0000_00C0);
        bus.step_btn = 1'b0;
        tick(3 * FRAME);

        #2;
        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL disp_drain: %0d pending, want 0", dq.size());
        end
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL sel_drain: %0d pending, want 0", sq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
